// File: rtl/tiny_nn_pkg.sv
// Shared tiny_nn types: 16-bit bfloat-style fp_t, special encodings, NaN test
// and the result transmitter's FSM states.
package tiny_nn_pkg;

    typedef logic [15:0] fp_t;

    localparam fp_t FPStdNaN = 16'hFFFF;
    localparam fp_t FPZero   = 16'h0000;
    localparam fp_t FPPosInf = 16'h7F80;
    localparam fp_t FPNegInf = 16'hFF80;

    typedef enum logic [1:0] {IDLE, SEND_HI, SEND_LO} tx_state_e;

    // Denormal patterns and negative zero are reserved as NaN encodings here.
    function automatic logic is_nan(fp_t v);
        return ((v[14:7] == 8'h00) && (v[6:0] != 7'h00)) ||
               (v == 16'h8000) ||
               ((v[14:7] == 8'hFF) && (v[6:0] != 7'h00));
    endfunction

endpackage

// File: rtl/tiny_nn_result_tx_if.sv
// Result-in / byte-out handshake bundle of tiny_nn_result_tx.
interface tiny_nn_result_tx_if;
    import tiny_nn_pkg::*;

    logic       res_valid_i;
    logic       res_ready_o;
    fp_t        res_i;
    logic       out_valid_o;
    logic       out_ready_i;
    logic [7:0] out_data_o;
    logic       nan_seen_o;
    logic       busy_o;

    modport slave (
        input  res_valid_i, res_i, out_ready_i,
        output res_ready_o, out_valid_o, out_data_o, nan_seen_o, busy_o
    );

    modport master (
        output res_valid_i, res_i, out_ready_i,
        input  res_ready_o, out_valid_o, out_data_o, nan_seen_o, busy_o
    );

endinterface

// File: rtl/tiny_nn_fifo.sv
// Synchronous circular-buffer FIFO; push ignored when full, pop ignored when empty.
module tiny_nn_fifo #(
    parameter int Width = 16,
    parameter int Depth = 4,
    localparam int PtrW = $clog2(Depth),
    localparam int CntW = $clog2(Depth + 1)
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             push,
    input  logic [Width-1:0] wdata,
    input  logic             pop,
    output logic [Width-1:0] rdata,
    output logic             full,
    output logic             empty,
    output logic [CntW-1:0]  count
);

    logic [Width-1:0] mem [Depth];
    logic [PtrW-1:0]  wptr, rptr;
    logic             do_push, do_pop;

    assign full    = (count == CntW'(Depth));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rdata   = mem[rptr];

    always_ff @(posedge clk_i) begin
        if (do_push) mem[wptr] <= wdata;
    end

    // Depth is a power of two, so pointers wrap by natural overflow.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (do_push) wptr <= wptr + PtrW'(1);
            if (do_pop)  rptr <= rptr + PtrW'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + CntW'(1);
                2'b01:   count <= count - CntW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/tiny_nn_result_tx.sv
// Buffers fp_t results and sends each as two bytes (high first), with every
// NaN encoding collapsed to FPStdNaN.
module tiny_nn_result_tx
    import tiny_nn_pkg::*;
#(
    parameter int FifoDepth = 4
) (
    input  logic                clk_i,
    input  logic                rst_i,
    tiny_nn_result_tx_if.slave  bus
);

    localparam int CntW = $clog2(FifoDepth + 1);

    fp_t             head, canon;
    logic            head_nan;
    logic            full, empty, pop, load;
    logic [CntW-1:0] count;

    tx_state_e state_q, state_d;
    fp_t       word_q, word_d;
    logic      valid_q, valid_d;
    logic      nan_seen_q, nan_d;

    tiny_nn_fifo #(.Width(16), .Depth(FifoDepth)) u_fifo (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .push  (bus.res_valid_i),
        .wdata (bus.res_i),
        .pop   (pop),
        .rdata (head),
        .full  (full),
        .empty (empty),
        .count (count)
    );

    assign head_nan = is_nan(head);
    assign canon    = head_nan ? FPStdNaN : head;

    // The byte on the bus is always the top of the shift register.
    always_comb begin
        state_d = state_q;
        word_d  = word_q;
        valid_d = valid_q;
        nan_d   = nan_seen_q;
        load    = 1'b0;
        case (state_q)
            IDLE:    load = !empty;
            SEND_HI: if (bus.out_ready_i) begin
                word_d  = {word_q[7:0], 8'h00};
                state_d = SEND_LO;
            end
            SEND_LO: if (bus.out_ready_i) begin
                if (!empty) begin
                    load = 1'b1;
                end else begin
                    valid_d = 1'b0;
                    word_d  = '0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        if (load) begin
            word_d  = canon;
            valid_d = 1'b1;
            nan_d   = nan_seen_q | head_nan;
            state_d = SEND_HI;
        end
        pop = load;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q    <= IDLE;
            word_q     <= '0;
            valid_q    <= 1'b0;
            nan_seen_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            word_q     <= word_d;
            valid_q    <= valid_d;
            nan_seen_q <= nan_d;
        end
    end

    assign bus.res_ready_o = !full;
    assign bus.out_valid_o = valid_q;
    assign bus.out_data_o  = word_q[15:8];
    assign bus.nan_seen_o  = nan_seen_q;
    assign bus.busy_o      = (count != '0) || (state_q != IDLE);

endmodule

// File: tb/tb_tiny_nn_result_tx.sv
// Directed bench for tiny_nn_result_tx: latency, NaN canonicalisation,
// backpressure, full FIFO, pointer wrap and asynchronous reset.
module tb_tiny_nn_result_tx;
    import tiny_nn_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    tiny_nn_result_tx_if bus();

    tiny_nn_result_tx #(.FifoDepth(4)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    int tests = 0;
    int fails = 0;

    // Stimulus helpers; all tasks start and end at posedge+1.
    task automatic push_word(input fp_t v);
        bit done = 0;
        bus.res_valid_i = 1'b1;
        bus.res_i       = v;
        for (int i = 0; i < 200 && !done; i++) begin
            done = bus.res_ready_o;
            @(posedge clk); #1;
        end
        bus.res_valid_i = 1'b0;
        tests++;
        if (!done) begin fails++; $display("FAIL push_timeout: word %h never accepted", v); end
    endtask

    task automatic get_byte(output logic [7:0] b, output bit ok);
        ok = 0;
        b  = 8'h00;
        bus.out_ready_i = 1'b1;
        for (int i = 0; i < 200 && !ok; i++) begin
            if (bus.out_valid_o) begin b = bus.out_data_o; ok = 1; end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_reset();
        #12;
        tests++;
        if ({bus.out_valid_o, bus.out_data_o, bus.nan_seen_o, bus.busy_o} !== 11'h0) begin
            fails++;
            $display("FAIL reset_outputs: valid=%b data=%h nan=%b busy=%b want all 0",
                     bus.out_valid_o, bus.out_data_o, bus.nan_seen_o, bus.busy_o);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        #1;
        tests++;
        if (bus.res_ready_o !== 1'b1) begin fails++; $display("FAIL reset_ready: got %b want 1", bus.res_ready_o); end
        @(posedge clk); #1;
    endtask

    task automatic test_single();
        bus.out_ready_i = 1'b1;
        bus.res_valid_i = 1'b1;
        bus.res_i       = 16'h3F80;
        @(posedge clk); #1;
        bus.res_valid_i = 1'b0;
        tests++;
        if (bus.out_valid_o !== 1'b0) begin fails++; $display("FAIL single_accept_edge: valid=%b want 0", bus.out_valid_o); end
        @(posedge clk); #1;
        tests++;
        if ({bus.out_valid_o, bus.out_data_o} !== 9'h13F) begin
            fails++; $display("FAIL single_hi: valid=%b data=%h want 1/3f", bus.out_valid_o, bus.out_data_o);
        end
        @(posedge clk); #1;
        tests++;
        if ({bus.out_valid_o, bus.out_data_o} !== 9'h180) begin
            fails++; $display("FAIL single_lo: valid=%b data=%h want 1/80", bus.out_valid_o, bus.out_data_o);
        end
        @(posedge clk); #1;
        tests++;
        if ({bus.out_valid_o, bus.out_data_o, bus.busy_o, bus.nan_seen_o} !== 11'h0) begin
            fails++; $display("FAIL single_idle: valid=%b data=%h busy=%b nan=%b want all 0",
                              bus.out_valid_o, bus.out_data_o, bus.busy_o, bus.nan_seen_o);
        end
    endtask

    task automatic test_nan();
        fp_t        vin  [5] = '{16'h0001, 16'h8000, 16'h7FC1, FPPosInf, FPZero};
        logic [7:0] want [10] = '{8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'h7F, 8'h80, 8'h00, 8'h00};
        logic [7:0] b;
        bit         ok;
        bus.out_ready_i = 1'b0;
        tests++;
        if (bus.nan_seen_o !== 1'b0) begin fails++; $display("FAIL nan_pre: nan_seen=%b want 0", bus.nan_seen_o); end
        for (int i = 0; i < 5; i++) push_word(vin[i]);
        @(posedge clk); #1;
        tests++;
        if ({bus.nan_seen_o, bus.res_ready_o} !== 2'b10) begin
            fails++; $display("FAIL nan_first_pop: nan_seen=%b ready=%b want 1/0", bus.nan_seen_o, bus.res_ready_o);
        end
        for (int i = 0; i < 10; i++) begin
            get_byte(b, ok);
            tests++;
            if (!ok || b !== want[i]) begin
                fails++; $display("FAIL nan_byte%0d: got %h (ok=%0d) want %h", i, b, ok, want[i]);
            end
        end
        tests++;
        if ({bus.nan_seen_o, bus.busy_o, bus.out_valid_o} !== 3'b100) begin
            fails++; $display("FAIL nan_sticky: nan=%b busy=%b valid=%b want 1/0/0",
                              bus.nan_seen_o, bus.busy_o, bus.out_valid_o);
        end
    endtask

    task automatic test_backpressure();
        logic [7:0] b0, b1;
        bit         ok0, ok1;
        bus.out_ready_i = 1'b0;
        push_word(16'hC040);
        @(posedge clk); #1;
        for (int i = 0; i < 5; i++) begin
            tests++;
            if ({bus.out_valid_o, bus.out_data_o} !== 9'h1C0) begin
                fails++; $display("FAIL bp_hold%0d: valid=%b data=%h want 1/c0", i, bus.out_valid_o, bus.out_data_o);
            end
            @(posedge clk); #1;
        end
        get_byte(b0, ok0);
        get_byte(b1, ok1);
        tests++;
        if (!(ok0 && ok1) || {b0, b1} !== 16'hC040) begin
            fails++; $display("FAIL bp_bytes: got %h %h want c0 40", b0, b1);
        end
        tests++;
        if (bus.out_valid_o !== 1'b0) begin fails++; $display("FAIL bp_idle: valid=%b want 0", bus.out_valid_o); end
    endtask

    task automatic test_full();
        int         acc = 0;
        int         got = 0;
        bit         a;
        logic [7:0] bytes [12];
        bus.out_ready_i = 1'b0;
        for (int c = 0; c < 12; c++) begin
            bus.res_valid_i = 1'b1;
            bus.res_i       = 16'h0101 + 16'(acc);
            a = bus.res_ready_o;
            @(posedge clk); #1;
            if (a) acc++;
        end
        tests++;
        if (acc != 5 || bus.res_ready_o !== 1'b0) begin
            fails++; $display("FAIL full_accept: accepted %0d ready=%b want 5/0", acc, bus.res_ready_o);
        end
        bus.out_ready_i = 1'b1;
        for (int c = 0; c < 100 && got < 12; c++) begin
            a = bus.res_valid_i && bus.res_ready_o;
            if (bus.out_valid_o) begin bytes[got] = bus.out_data_o; got++; end
            @(posedge clk); #1;
            if (a) bus.res_valid_i = 1'b0;
        end
        tests++;
        if (got != 12 || bus.res_valid_i !== 1'b0) begin
            fails++; $display("FAIL full_drain: got %0d bytes, stalled word pending=%b want 12/0", got, bus.res_valid_i);
        end
        for (int w = 0; w < 6; w++) begin
            tests++;
            if ({bytes[2*w], bytes[2*w+1]} !== 16'h0101 + 16'(w)) begin
                fails++; $display("FAIL full_word%0d: got %h%h want %h", w, bytes[2*w], bytes[2*w+1], 16'h0101 + 16'(w));
            end
        end
    endtask

    task automatic test_wrap();
        fp_t exp_q[$];
        int  got_words = 0;
        fork
            begin
                for (int i = 0; i < 13; i++) begin
                    logic       s;
                    logic [7:0] e;
                    logic [6:0] m;
                    s = 1'($urandom);
                    e = 8'($urandom_range(254, 1));
                    m = 7'($urandom);
                    exp_q.push_back({s, e, m});
                    push_word({s, e, m});
                end
            end
            begin
                logic [7:0] hi;
                bit         have_hi = 0;
                for (int c = 0; c < 2000 && got_words < 13; c++) begin
                    bus.out_ready_i = 1'($urandom);
                    if (bus.out_valid_o && bus.out_ready_i) begin
                        if (!have_hi) begin
                            hi = bus.out_data_o; have_hi = 1;
                        end else begin
                            fp_t w, ew;
                            w  = {hi, bus.out_data_o};
                            ew = (exp_q.size() != 0) ? exp_q.pop_front() : 16'hxxxx;
                            have_hi = 0;
                            tests++;
                            if (w !== ew) begin fails++; $display("FAIL wrap_word%0d: got %h want %h", got_words, w, ew); end
                            got_words++;
                        end
                    end
                    @(posedge clk); #1;
                end
            end
        join
        tests++;
        if (got_words != 13) begin fails++; $display("FAIL wrap_count: got %0d words want 13", got_words); end
        bus.out_ready_i = 1'b0;
    endtask

    task automatic test_async_reset();
        logic [7:0] b0, b1;
        bit         ok0, ok1;
        bus.out_ready_i = 1'b0;
        push_word(16'h4000);
        @(posedge clk); #1;
        bus.out_ready_i = 1'b1;
        @(posedge clk); #1;
        bus.out_ready_i = 1'b0;
        tests++;
        if ({bus.out_valid_o, bus.out_data_o} !== 9'h100) begin
            fails++; $display("FAIL ar_lo_pending: valid=%b data=%h want 1/00", bus.out_valid_o, bus.out_data_o);
        end
        #2 rst = 1'b1;
        #1;
        tests++;
        if ({bus.out_valid_o, bus.busy_o, bus.nan_seen_o, bus.out_data_o} !== 11'h0) begin
            fails++; $display("FAIL ar_immediate: valid=%b busy=%b nan=%b data=%h want all 0",
                              bus.out_valid_o, bus.busy_o, bus.nan_seen_o, bus.out_data_o);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        push_word(16'h3F80);
        get_byte(b0, ok0);
        get_byte(b1, ok1);
        tests++;
        if (!(ok0 && ok1) || {b0, b1} !== 16'h3F80) begin
            fails++; $display("FAIL ar_resync: got %h %h want 3f 80", b0, b1);
        end
        tests++;
        if (bus.busy_o !== 1'b0) begin fails++; $display("FAIL ar_idle: busy=%b want 0", bus.busy_o); end
    endtask

    initial begin
        bus.res_valid_i = 1'b0;
        bus.res_i       = '0;
        bus.out_ready_i = 1'b0;
        test_reset();
        test_single();
        test_nan();
        test_backpressure();
        test_full();
        test_wrap();
        test_async_reset();
        tests++;
        if (FPNegInf !== 16'hFF80 && is_nan(FPNegInf)) begin fails++; $display("FAIL neginf_const"); end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/tiny_nn_result_tx.md
Name: tiny_nn_result_tx

Overview:
- Transmit end of the tiny_nn result path. Accepts fp_t results from the compute datapath (convolve/accumulate units) over a valid/ready handshake.
- Buffers results in a small FIFO and serialises each one onto an 8-bit output bus with its own valid/ready handshake, high byte first.
- Canonicalises every NaN encoding to FPStdNaN before transmission, so the off-chip reader only ever sees one NaN pattern.

Parameters:
- FifoDepth, 4, number of fp_t entries buffered; power of two, >= 2.

Ports:
- clk_i  input  1  clock.
- rst_i  input  1  reset, asynchronous, active-high.
- res_valid_i  input  1  result valid from datapath.
- res_ready_o  output  1  block can accept a result this cycle.
- res_i  input  16 (fp_t)  result value.
- out_valid_o  output  1  out_data_o holds a valid byte.
- out_ready_i  input  1  downstream consumes the byte this cycle.
- out_data_o  output  8  serialised byte.
- nan_seen_o  output  1  sticky: at least one transmitted value was canonicalised NaN.
- busy_o  output  1  FIFO non-empty or a transfer in progress.

Behaviour:
- Clock and reset: one clock, clk_i. Reset rst_i is asynchronous and active-high.
- Reset values: res_ready_o=1 once reset deasserts (combinational !full), out_valid_o=0, out_data_o=8'h00, nan_seen_o=0, busy_o=0, FIFO empty (pointers and count 0), FSM=IDLE.
- Input handshake:
  - Transfer when res_valid_i && res_ready_o at a rising edge.
  - res_ready_o = !full. It does not depend on a same-cycle pop (no comb path from out_ready_i).
  - When full, res_valid_i is ignored and no data is lost or overwritten.
- FIFO:
  - Circular buffer with read/write pointers of clog2(FifoDepth) bits that wrap modulo FifoDepth.
  - Count register is 0..FifoDepth.
  - Simultaneous push and pop: count unchanged, both pointers advance.
- FSM states: IDLE, SEND_HI, SEND_LO.
  - IDLE: if FIFO non-empty, pop head, canonicalise, hold the 16-bit word in a shift register, drive out_data_o = word[15:8], out_valid_o=1, go to SEND_HI.
  - SEND_HI: hold until out_ready_i. On handshake, out_data_o = word[7:0], go to SEND_LO.
  - SEND_LO: hold until out_ready_i. On handshake:
    - if FIFO non-empty, pop next, load its high byte, go to SEND_HI (back-to-back, no bubble);
    - else out_valid_o=0, out_data_o=8'h00, go to IDLE.
- Output stability: out_valid_o and out_data_o are registered outputs and never change while out_valid_o=1 && !out_ready_i.
- Latency: result accepted at edge E with FIFO empty and FSM in IDLE gives out_valid_o=1 with the high byte after edge E+1. Sustained throughput is 1 result per 2 cycles with out_ready_i held high.
- Canonicalisation, applied at pop:
  - If is_nan(value), transmit FPStdNaN (16'hFFFF) and set nan_seen_o.
  - This covers exp=0 with mant!=0, the negative-zero pattern 16'h8000, and exp=all-ones with mant!=0.
  - FPPosInf, FPNegInf and FPZero pass unchanged.
- nan_seen_o is sticky until reset.
- busy_o = (count!=0) || (state!=IDLE).
- Reset mid-transfer: all state cleared immediately and asynchronously. A partially sent word is discarded, and the receiver must resynchronise on reset.

Decomposition:
- Shared package tiny_nn_pkg holds fp_t, FPStdNaN, FPZero, FPPosInf, FPNegInf and is_nan.
- Add to the package: tx_state_e enum {IDLE, SEND_HI, SEND_LO}.
- One natural sub-module: tiny_nn_fifo, a parameterised width/depth sync FIFO with full/empty outputs. The FSM and canonicalisation stay in tiny_nn_result_tx.

Test Plan:
- Single value: push 16'h3F80 (1.0), out_ready_i=1 -> bytes 8'h3F then 8'h80 on consecutive cycles, first out_valid_o one cycle after accept. Then IDLE, busy_o=0, nan_seen_o=0.
- NaN canonicalisation: push 16'h0001, 16'h8000, 16'h7FC1, 16'h7F80, 16'h0000 -> byte stream FF FF FF FF FF FF 7F 80 00 00. nan_seen_o rises with the first pop and stays 1.
- Backpressure: push 16'hC040 with out_ready_i=0 for 5 cycles -> out_data_o holds 8'hC0 and out_valid_o holds 1. Raise out_ready_i -> 8'hC0 accepted, then 8'h40.
- Full FIFO: out_ready_i=0, push 16'h0101..16'h0106 continuously -> 1 word in the FSM plus 4 in the FIFO accepted, then res_ready_o=0 and 16'h0106 stalls. Release out_ready_i -> words 0101..0105 appear in order, then 0106, with no loss or duplication.
- Pointer wrap: stream 3*FifoDepth+1 random non-NaN values with random out_ready_i -> output equals input order exactly; scoreboard match.
- Async reset mid-transfer: assert rst_i between the high and low byte of 16'h4000, without a clock edge -> out_valid_o=0, busy_o=0 immediately. After deassertion, pushing 16'h3F80 yields 3F, 80 with no stale 8'h00 byte.
